// File: rtl/ccg_scan_pkg.sv
// Shared types and helpers for the truth-table scanner.
package ccg_scan_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SEND   = 2'd2,
      DONE   = 2'd3
   } scan_state_t;

   localparam int unsigned SIG_W_DEF = 16;

   // Rotate left by one within the low w bits; widths up to 64 are supported.
   function automatic logic [63:0] rotl1(input logic [63:0] v, input int unsigned w);
      logic [63:0] mask;
      mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return ((v << 1) | ((v >> (w - 1)) & 64'd1)) & mask;
   endfunction

endpackage

// File: rtl/ccg_sig_accum.sv
// Rotating-XOR signature register: sig <= rotl1(sig) ^ zero_ext(din) when enabled.
module ccg_sig_accum
   import ccg_scan_pkg::*;
#(
   parameter int unsigned N_OUT = 10,
   parameter int unsigned SIG_W = SIG_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [N_OUT-1:0] din,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clr) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = SIG_W'(rotl1(64'(sig_q), SIG_W)) ^ SIG_W'(din);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/ccg_truth_table_scanner.sv
// Walks a combinational DUT through every input code, captures its outputs after a
// settle window, streams {index, outputs} records and folds them into a signature.
module ccg_truth_table_scanner
   import ccg_scan_pkg::*;
#(
   parameter int unsigned N_IN          = 3,
   parameter int unsigned N_OUT         = 10,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned SIG_W         = SIG_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [N_IN-1:0]  dut_x,
   input  logic [N_OUT-1:0] dut_f,
   output logic             rec_valid,
   input  logic             rec_ready,
   output logic [N_IN-1:0]  rec_idx,
   output logic [N_OUT-1:0] rec_f,
   output logic             rec_last,
   output logic [SIG_W-1:0] sig_out
);

   localparam int unsigned   CNT_W    = $clog2(SETTLE_CYCLES + 1);
   localparam logic [N_IN:0] LAST_IDX = {1'b0, {N_IN{1'b1}}};

   scan_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_IN:0]    idx_q, idx_d;
   logic [N_IN-1:0]  dut_x_q, dut_x_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             rec_valid_q, rec_valid_d;
   logic [N_IN-1:0]  rec_idx_q, rec_idx_d;
   logic [N_OUT-1:0] rec_f_q, rec_f_d;
   logic             rec_last_q, rec_last_d;
   logic [SIG_W-1:0] sig_out_q, sig_out_d;
   logic             sig_clr;
   logic             sig_en;
   logic [SIG_W-1:0] sig;

   ccg_sig_accum #(
      .N_OUT (N_OUT),
      .SIG_W (SIG_W)
   ) u_sig_accum (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (sig_clr),
      .en    (sig_en),
      .din   (rec_f_q),
      .sig   (sig)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      dut_x_d     = dut_x_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      rec_valid_d = rec_valid_q;
      rec_idx_d   = rec_idx_q;
      rec_f_d     = rec_f_q;
      rec_last_d  = rec_last_q;
      sig_out_d   = sig_out_q;
      sig_clr     = 1'b0;
      sig_en      = 1'b0;

      // Abort overrides everything, including a same-cycle handshake and the DONE update.
      if (abort && (state_q != IDLE)) begin
         state_d     = IDLE;
         cnt_d       = '0;
         idx_d       = '0;
         dut_x_d     = '0;
         busy_d      = 1'b0;
         rec_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = SETTLE;
                  cnt_d   = '0;
                  idx_d   = '0;
                  dut_x_d = '0;
                  busy_d  = 1'b1;
                  sig_clr = 1'b1;
               end
            end
            SETTLE: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                  state_d     = SEND;
                  rec_f_d     = dut_f;
                  rec_idx_d   = idx_q[N_IN-1:0];
                  rec_last_d  = (idx_q == LAST_IDX);
                  rec_valid_d = 1'b1;
               end
            end
            SEND: begin
               if (rec_ready) begin
                  sig_en      = 1'b1;
                  rec_valid_d = 1'b0;
                  if (rec_last_q) begin
                     state_d = DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = SETTLE;
                     idx_d   = idx_q + 1'b1;
                     dut_x_d = idx_d[N_IN-1:0];
                     cnt_d   = '0;
                  end
               end
            end
            DONE: begin
               state_d   = IDLE;
               sig_out_d = sig;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         dut_x_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rec_valid_q <= 1'b0;
         rec_idx_q   <= '0;
         rec_f_q     <= '0;
         rec_last_q  <= 1'b0;
         sig_out_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         dut_x_q     <= dut_x_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rec_valid_q <= rec_valid_d;
         rec_idx_q   <= rec_idx_d;
         rec_f_q     <= rec_f_d;
         rec_last_q  <= rec_last_d;
         sig_out_q   <= sig_out_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign dut_x     = dut_x_q;
   assign rec_valid = rec_valid_q;
   assign rec_idx   = rec_idx_q;
   assign rec_f     = rec_f_q;
   assign rec_last  = rec_last_q;
   assign sig_out   = sig_out_q;

endmodule

// File: tb/tb_ccg_truth_table_scanner.sv
// Directed bench for ccg_truth_table_scanner using a stub combinational DUT.
module tb_ccg_truth_table_scanner;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic [2:0]  dut_x;
   logic [9:0]  dut_f;
   logic        rec_valid;
   logic        rec_ready;
   logic [2:0]  rec_idx;
   logic [9:0]  rec_f;
   logic        rec_last;
   logic [15:0] sig_out;
   logic        stub_mode;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2:0] idx;
      logic [9:0] f;
      logic       last;
   } rec_t;

   rec_t tab[8];

   ccg_truth_table_scanner #(
      .N_IN          (3),
      .N_OUT         (10),
      .SETTLE_CYCLES (2),
      .SIG_W         (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .dut_x     (dut_x),
      .dut_f     (dut_f),
      .rec_valid (rec_valid),
      .rec_ready (rec_ready),
      .rec_idx   (rec_idx),
      .rec_f     (rec_f),
      .rec_last  (rec_last),
      .sig_out   (sig_out)
   );

   always_comb dut_f = stub_mode ? 10'h3FF : {7'b0, dut_x};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic run_scan(input int stall_idx, input int stall_len,
                           output int done_cyc, output int nrec);
      int         stalls;
      logic       seen;
      logic [2:0] s_idx;
      logic [9:0] s_f;
      logic [2:0] s_x;
      logic [9:0] exp_f;
      stalls   = 0;
      nrec     = 0;
      done_cyc = -1;
      seen     = 1'b0;
      s_idx    = '0;
      s_f      = '0;
      s_x      = '0;
      rec_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("accept_busy", 32'(busy), 32'd1);
      check("accept_dut_x", 32'(dut_x), 32'd0);
      for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
         tick();
         if (rec_valid) begin
            if (int'(rec_idx) == stall_idx && stalls < stall_len) begin
               if (stalls == 0) begin
                  s_idx = rec_idx;
                  s_f   = rec_f;
                  s_x   = dut_x;
               end else begin
                  check("stall_rec_idx", 32'(rec_idx), 32'(s_idx));
                  check("stall_rec_f", 32'(rec_f), 32'(s_f));
                  check("stall_dut_x", 32'(dut_x), 32'(s_x));
               end
               rec_ready = 1'b0;
               stalls++;
            end else begin
               if (stalls > 0 && int'(rec_idx) == stall_idx) begin
                  check("stall_end_rec_f", 32'(rec_f), 32'(s_f));
                  check("stall_end_dut_x", 32'(dut_x), 32'(s_x));
               end
               rec_ready = 1'b1;
               if (nrec < 8) begin
                  exp_f = stub_mode ? 10'h3FF : tab[nrec].f;
                  check("rec_idx", 32'(rec_idx), 32'(tab[nrec].idx));
                  check("rec_f", 32'(rec_f), 32'(exp_f));
                  check("rec_last", 32'(rec_last), 32'(tab[nrec].last));
               end else begin
                  check("extra_record", 32'(nrec), 32'd7);
               end
               nrec++;
            end
         end
         if (done) begin
            done_cyc = cyc;
            seen     = 1'b1;
            check("done_busy_low", 32'(busy), 32'd0);
         end
      end
      if (!seen) check("done_timeout", 32'd0, 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("done_one_cycle", 32'(done), 32'd0);
      check("start_at_done_ignored", 32'(busy), 32'd0);
   endtask

   initial begin
      int   done_cyc;
      int   nrec;
      logic any_done;

      tab[0] = '{3'd0, 10'd0, 1'b0};
      tab[1] = '{3'd1, 10'd1, 1'b0};
      tab[2] = '{3'd2, 10'd2, 1'b0};
      tab[3] = '{3'd3, 10'd3, 1'b0};
      tab[4] = '{3'd4, 10'd4, 1'b0};
      tab[5] = '{3'd5, 10'd5, 1'b0};
      tab[6] = '{3'd6, 10'd6, 1'b0};
      tab[7] = '{3'd7, 10'd7, 1'b1};

      rst_n     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      rec_ready = 1'b1;
      stub_mode = 1'b0;
      repeat (3) tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rec_valid", 32'(rec_valid), 32'd0);
      check("rst_dut_x", 32'(dut_x), 32'd0);
      check("rst_sig_out", 32'(sig_out), 32'd0);
      rst_n = 1'b1;
      tick();

      // Full scan, f = x; signature of 0..7 is 16'h000F.
      run_scan(-1, 0, done_cyc, nrec);
      check("scan1_done_cycle", 32'(done_cyc), 32'd24);
      check("scan1_nrec", 32'(nrec), 32'd8);
      check("scan1_sig_out", 32'(sig_out), 32'h000F);

      // Constant 3FF outputs.
      stub_mode = 1'b1;
      run_scan(-1, 0, done_cyc, nrec);
      check("sig_3ff_nrec", 32'(nrec), 32'd8);
      check("sig_3ff_sig_out", 32'(sig_out), 32'h5454);
      stub_mode = 1'b0;

      // Backpressure on idx 3.
      run_scan(3, 5, done_cyc, nrec);
      check("bp_done_cycle", 32'(done_cyc), 32'd29);
      check("bp_nrec", 32'(nrec), 32'd8);
      check("bp_sig_out", 32'(sig_out), 32'h000F);

      // Abort during SETTLE of idx 5.
      rec_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 100 && dut_x != 3'd5; i++) tick();
      check("ab_reach_idx5", 32'(dut_x), 32'd5);
      check("ab_in_settle", 32'(rec_valid), 32'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_busy", 32'(busy), 32'd0);
      check("ab_rec_valid", 32'(rec_valid), 32'd0);
      check("ab_dut_x", 32'(dut_x), 32'd0);
      any_done = done;
      for (int i = 0; i < 40; i++) begin
         tick();
         any_done = any_done | done | busy;
      end
      check("ab_no_done", 32'(any_done), 32'd0);
      check("ab_sig_out", 32'(sig_out), 32'h000F);

      // Abort together with handshake of idx 2.
      rec_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 100 && !(rec_valid && rec_idx == 3'd2); i++) tick();
      check("abhs_reach_idx2", 32'(rec_valid && rec_idx == 3'd2), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abhs_busy", 32'(busy), 32'd0);
      check("abhs_rec_valid", 32'(rec_valid), 32'd0);
      check("abhs_dut_x", 32'(dut_x), 32'd0);
      check("abhs_done", 32'(done), 32'd0);
      check("abhs_sig_out", 32'(sig_out), 32'h000F);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("abhs_idle_accepts_start", 32'(busy), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abhs_second_abort", 32'(busy), 32'd0);

      // Start mid-scan, then asynchronous reset while holding a record in SEND.
      rec_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 100 && dut_x != 3'd2; i++) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("mid_start_busy", 32'(busy), 32'd1);
      check("mid_start_dut_x", 32'(dut_x), 32'd2);
      for (int i = 0; i < 100 && !(rec_valid && rec_idx == 3'd4); i++) tick();
      rec_ready = 1'b0;
      tick();
      check("rst_mid_pre_idx", 32'(rec_idx), 32'd4);
      check("rst_mid_pre_valid", 32'(rec_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_rec_valid", 32'(rec_valid), 32'd0);
      check("rst_mid_rec_idx", 32'(rec_idx), 32'd0);
      check("rst_mid_rec_f", 32'(rec_f), 32'd0);
      check("rst_mid_rec_last", 32'(rec_last), 32'd0);
      check("rst_mid_dut_x", 32'(dut_x), 32'd0);
      check("rst_mid_sig_out", 32'(sig_out), 32'd0);
      #2;
      rst_n = 1'b1;
      rec_ready = 1'b1;
      tick();
      run_scan(-1, 0, done_cyc, nrec);
      check("rescan_done_cycle", 32'(done_cyc), 32'd24);
      check("rescan_nrec", 32'(nrec), 32'd8);
      check("rescan_sig_out", 32'(sig_out), 32'h000F);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
